// File: rtl/cmd_select_ctrl.sv
// cmd_select_ctrl
// Operator command entry stage. Three active-low push-buttons (next, prev,
// exec) are synchronized and debounced. The debounced press events step a
// registered command index. An exec press offers that command downstream
// over a valid/ready handshake. One exec press issues exactly one command.
module cmd_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20,
   parameter int NUM_CMDS        = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_next,
   input  logic       btn_prev,
   input  logic       btn_exec,
   input  logic       cmd_ready,
   output logic [2:0] cmd,
   output logic       cmd_valid,
   output logic       sel_mode
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0]       CMD_MAX  = 3'(NUM_CMDS - 1);

   // Button order in the vectors below: bit 0 = next, 1 = prev, 2 = exec
   logic [2:0] btn_raw;
   logic [2:0] press_ev;
   logic       exec_lvl;

   assign btn_raw = {btn_exec, btn_prev, btn_next};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         logic             sync1_reg;
         logic             sync2_reg;
         logic             deb_reg;
         logic             deb_dly_reg;
         logic [CNT_W-1:0] cnt_reg;

         // Two-flop synchronizer, then a debouncer that accepts a new level
         // only after it has been stable for DEBOUNCE_CYCLES cycles
         always_ff @(posedge clk) begin
            if (rst) begin
               sync1_reg   <= 1'b1;
               sync2_reg   <= 1'b1;
               deb_reg     <= 1'b1;
               deb_dly_reg <= 1'b1;
               cnt_reg     <= '0;
            end else begin
               sync1_reg   <= btn_raw[gi];
               sync2_reg   <= sync1_reg;
               deb_dly_reg <= deb_reg;
               if (sync2_reg == deb_reg) begin
                  cnt_reg <= '0;
               end else if (cnt_reg == CNT_LAST) begin
                  deb_reg <= sync2_reg;
                  cnt_reg <= '0;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
         end

         // One-cycle pulse on the debounced released->pressed transition
         assign press_ev[gi] = deb_dly_reg & ~deb_reg;

         if (gi == 2) begin : g_exec_lvl
            assign exec_lvl = deb_reg;
         end
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_SEL   = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t     state_reg,  state_next;
   logic [2:0] cmd_reg,    cmd_next;
   logic       valid_reg,  valid_next;
   logic       sel_reg,    sel_next;

   // Control state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_SEL;
         cmd_reg   <= 3'd0;
         valid_reg <= 1'b0;
         sel_reg   <= 1'b1;
      end else begin
         state_reg <= state_next;
         cmd_reg   <= cmd_next;
         valid_reg <= valid_next;
         sel_reg   <= sel_next;
      end
   end

   // Next-state logic; events outside SEL are simply dropped
   always_comb begin
      state_next = state_reg;
      cmd_next   = cmd_reg;
      valid_next = valid_reg;
      sel_next   = sel_reg;
      case (state_reg)
         ST_SEL: begin
            if (press_ev[2]) begin
               // exec wins over a simultaneous next/prev; command is frozen
               state_next = ST_ISSUE;
               valid_next = 1'b1;
               sel_next   = 1'b0;
            end else if (press_ev[0] && !press_ev[1]) begin
               cmd_next = (cmd_reg == CMD_MAX) ? 3'd0 : cmd_reg + 3'd1;
            end else if (press_ev[1] && !press_ev[0]) begin
               cmd_next = (cmd_reg == 3'd0) ? CMD_MAX : cmd_reg - 3'd1;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               valid_next = 1'b0;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Wait for exec release so a held button cannot re-issue
            if (exec_lvl) begin
               state_next = ST_SEL;
               sel_next   = 1'b1;
            end
         end
         default: begin
            state_next = ST_SEL;
            cmd_next   = 3'd0;
            valid_next = 1'b0;
            sel_next   = 1'b1;
         end
      endcase
   end

   assign cmd       = cmd_reg;
   assign cmd_valid = valid_reg;
   assign sel_mode  = sel_reg;

endmodule

// File: tb/tb_cmd_select_ctrl.sv
// Bench for cmd_select_ctrl with a 4-cycle debounce. Every expected change of
// {cmd, cmd_valid, sel_mode} is queued when stimulus is driven; a negedge
// monitor pops and compares on each observed change. Directed checks cover
// edge-exact latency, wrap-around, glitch rejection, handshake and reset.
module tb_cmd_select_ctrl;

   localparam int DEB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_next;
   logic       btn_prev;
   logic       btn_exec;
   logic       cmd_ready;
   logic [2:0] cmd;
   logic       cmd_valid;
   logic       sel_mode;

   int vectors     = 0;
   int miscompares = 0;

   logic [4:0] sb_q[$];
   logic [4:0] prev_obs;

   cmd_select_ctrl #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W(3),
      .NUM_CMDS(6)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_next(btn_next),
      .btn_prev(btn_prev),
      .btn_exec(btn_exec),
      .cmd_ready(cmd_ready),
      .cmd(cmd),
      .cmd_valid(cmd_valid),
      .sel_mode(sel_mode)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] c, input logic v, input logic s);
      sb_q.push_back({c, v, s});
   endtask

   task automatic set_btn(input int which, input logic lvl);
      case (which)
         0:       btn_next = lvl;
         1:       btn_prev = lvl;
         default: btn_exec = lvl;
      endcase
   endtask

   task automatic press(input int which, input int low, input int high);
      set_btn(which, 1'b0);
      repeat (low) tick();
      set_btn(which, 1'b1);
      repeat (high) tick();
   endtask

   // Scoreboard monitor: each output change must match the oldest queued entry
   always @(negedge clk) begin
      logic [4:0] obs;
      logic [4:0] exp;
      obs = {cmd, cmd_valid, sel_mode};
      if (rst) begin
         prev_obs = obs;
      end else if (obs !== prev_obs) begin
         vectors++;
         if (sb_q.size() == 0) begin
            assert (0) else begin
               miscompares++;
               $error("FAIL sb_unexpected observed={cmd,valid,sel}=%b expected=no change", obs);
            end
         end else begin
            exp = sb_q.pop_front();
            assert (obs === exp) else begin
               miscompares++;
               $error("FAIL sb_output observed={cmd,valid,sel}=%b expected=%b", obs, exp);
            end
         end
         prev_obs = obs;
      end
   end

   initial begin
      int vcount;
      rst       = 1'b1;
      btn_next  = 1'b1;
      btn_prev  = 1'b1;
      btn_exec  = 1'b1;
      cmd_ready = 1'b1;
      repeat (3) tick();
      check("reset_cmd", cmd, 0);
      check("reset_valid", cmd_valid, 0);
      check("reset_sel", sel_mode, 1);
      rst = 1'b0;
      repeat (3) tick();

      // 1: three clean NEXT presses, update exactly on the 7th edge
      for (int i = 1; i <= 3; i++) begin
         btn_next = 1'b0;
         push(3'(i), 1'b0, 1'b1);
         repeat (DEB + 2) tick();
         check("next_before_edge7", cmd, i - 1);
         tick();
         check("next_on_edge7", cmd, i);
         check("next_valid_low", cmd_valid, 0);
         repeat (3) tick();
         btn_next = 1'b1;
         repeat (10) tick();
      end

      // 2: wrap in both directions, simultaneous next+prev
      push(3'd4, 1'b0, 1'b1);
      press(0, 10, 10);
      push(3'd5, 1'b0, 1'b1);
      press(0, 10, 10);
      check("cmd_at_5", cmd, 5);
      push(3'd0, 1'b0, 1'b1);
      press(0, 10, 10);
      check("wrap_next_5_to_0", cmd, 0);
      push(3'd5, 1'b0, 1'b1);
      press(1, 10, 10);
      check("wrap_prev_0_to_5", cmd, 5);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (10) tick();
      btn_next = 1'b1;
      btn_prev = 1'b1;
      repeat (10) tick();
      check("next_prev_same_cycle", cmd, 5);

      // 3: glitches shorter than the debounce window
      for (int g = 0; g < 8; g++) begin
         btn_next = 1'b0;
         repeat (DEB - 1) tick();
         btn_next = 1'b1;
         tick();
      end
      repeat (10) tick();
      check("glitch_no_change", cmd, 5);

      // 4: issue cmd 2 with ready held low for 5 cycles, next ignored
      push(3'd0, 1'b0, 1'b1);
      press(0, 10, 10);
      push(3'd1, 1'b0, 1'b1);
      press(0, 10, 10);
      push(3'd2, 1'b0, 1'b1);
      press(0, 10, 10);
      check("cmd_at_2", cmd, 2);
      cmd_ready = 1'b0;
      btn_exec  = 1'b0;
      push(3'd2, 1'b1, 1'b0);
      repeat (DEB + 2) tick();
      check("exec_before_edge7", cmd_valid, 0);
      tick();
      check("exec_valid_edge7", cmd_valid, 1);
      check("exec_sel_low", sel_mode, 0);
      push(3'd2, 1'b0, 1'b0);
      vcount = 0;
      for (int k = 0; k < 20; k++) begin
         if (cmd_valid) vcount++;
         check("issue_cmd_stable", cmd, 2);
         if (k == 1) btn_next = 1'b0;
         if (k == 5) cmd_ready = 1'b1;
         if (k == 12) btn_next = 1'b1;
         tick();
      end
      check("issue_valid_cycles", vcount, 6);
      check("hold_sel_low", sel_mode, 0);
      btn_exec = 1'b1;
      push(3'd2, 1'b0, 1'b1);
      repeat (DEB + 2) tick();
      check("hold_sel_before_release", sel_mode, 0);
      tick();
      check("sel_after_release", sel_mode, 1);
      check("cmd_kept_after_next_in_issue", cmd, 2);
      repeat (5) tick();

      // 5: exec held 100 cycles with ready high -> single pulse
      btn_exec = 1'b0;
      push(3'd2, 1'b1, 1'b0);
      push(3'd2, 1'b0, 1'b0);
      vcount = 0;
      repeat (100) begin
         tick();
         if (cmd_valid) vcount++;
      end
      check("long_exec_one_pulse", vcount, 1);
      btn_exec = 1'b1;
      push(3'd2, 1'b0, 1'b1);
      vcount = 0;
      repeat (20) begin
         tick();
         if (cmd_valid) vcount++;
      end
      check("no_pulse_on_release", vcount, 0);
      check("long_exec_sel_back", sel_mode, 1);

      // 6: reset during ISSUE, exec held through reset
      cmd_ready = 1'b0;
      btn_exec  = 1'b0;
      push(3'd2, 1'b1, 1'b0);
      repeat (DEB + 4) tick();
      check("pre_reset_in_issue", cmd_valid, 1);
      rst = 1'b1;
      tick();
      check("midrst_cmd", cmd, 0);
      check("midrst_valid", cmd_valid, 0);
      check("midrst_sel", sel_mode, 1);
      repeat (2) tick();
      rst = 1'b0;
      push(3'd0, 1'b1, 1'b0);
      repeat (DEB + 2) tick();
      check("held_exec_before_edge7", cmd_valid, 0);
      tick();
      check("held_exec_valid_edge7", cmd_valid, 1);
      check("held_exec_cmd", cmd, 0);
      cmd_ready = 1'b1;
      push(3'd0, 1'b0, 1'b0);
      tick();
      check("held_exec_handshake", cmd_valid, 0);
      btn_exec = 1'b1;
      push(3'd0, 1'b0, 1'b1);
      repeat (12) tick();
      check("final_sel", sel_mode, 1);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
